// File: rtl/fll_cfg_master.sv
// fll_cfg_master: turns single read/write commands into four-phase req/ack
// transactions on the FLL configuration interface, returns the result on a
// held response port, and synchronises the FLL lock indication.
`timescale 1ns/1ps

module fll_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [1:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  // FLL configuration interface
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  // lock
  input  logic        fll_lock_i,
  output logic        lock_o,
  output logic        lock_lost_o
);

  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;
  logic              req_d, wrn_d, rsp_valid_d, err_d;
  logic [1:0]        add_d;
  logic [31:0]       data_d, rdata_d;
  logic [NSYNC-1:0]  sync_q;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // State, phase counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fll_req_o   <= 1'b0;
      fll_wrn_o   <= 1'b0;
      fll_add_o   <= 2'd0;
      fll_data_o  <= 32'd0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fll_req_o   <= req_d;
      fll_wrn_o   <= wrn_d;
      fll_add_o   <= add_d;
      fll_data_o  <= data_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rdata_d;
      rsp_err_o   <= err_d;
    end
  end

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = fll_req_o;
    wrn_d       = fll_wrn_o;
    add_d       = fll_add_o;
    data_d      = fll_data_o;
    rsp_valid_d = rsp_valid_o;
    rdata_d     = rsp_rdata_o;
    err_d       = rsp_err_o;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          wrn_d   = ~cmd_wr_i;
          add_d   = cmd_addr_i;
          data_d  = cmd_wdata_i;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end

      ST_REQ: begin
        // Ack wins over a timeout landing on the same cycle.
        if (fll_ack_i) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          req_d   = 1'b0;
          rdata_d = fll_wrn_o ? fll_r_data_i : 32'd0;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          req_d   = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (!fll_ack_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = 32'd0;
          err_d       = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lock synchroniser; the loss pulse coincides with lock_o falling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      lock_lost_o <= 1'b0;
    end else begin
      sync_q      <= {sync_q[NSYNC-2:0], fll_lock_i};
      lock_lost_o <= sync_q[NSYNC-1] & ~sync_q[NSYNC-2];
    end
  end

  assign lock_o = sync_q[NSYNC-1];

endmodule

// File: tb/tb_fll_cfg_master.sv
// Self-checking bench for fll_cfg_master: directed and randomized commands
// against a configurable responder, with expected timing and results derived
// from the transaction rules as plain arithmetic.
`timescale 1ns/1ps

module tb_fll_cfg_master;

  localparam int unsigned T = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [1:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        fll_req_o, fll_wrn_o, fll_ack_i;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o, fll_r_data_i;
  logic        fll_lock_i, lock_o, lock_lost_o;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // responder configuration
  int          ack_delay = 0;
  int          ack_hold  = 0;
  logic [31:0] resp_rdata = 32'd0;
  int          req_cnt;
  int          hold_cnt;

  always #5 clk_i = ~clk_i;

  fll_cfg_master #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_wr_i     (cmd_wr_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .fll_req_o    (fll_req_o),
    .fll_wrn_o    (fll_wrn_o),
    .fll_add_o    (fll_add_o),
    .fll_data_o   (fll_data_o),
    .fll_ack_i    (fll_ack_i),
    .fll_r_data_i (fll_r_data_i),
    .fll_lock_i   (fll_lock_i),
    .lock_o       (lock_o),
    .lock_lost_o  (lock_lost_o)
  );

  // Responder: ack rises ack_delay cycles into req (combinational when 0)
  // and lingers ack_hold cycles after req drops.
  assign fll_ack_i    = (fll_req_o && (req_cnt >= ack_delay)) || (hold_cnt != 0);
  assign fll_r_data_i = fll_ack_i ? resp_rdata : 32'hBAD0_F00D;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_cnt  <= 0;
      hold_cnt <= 0;
    end else begin
      req_cnt <= fll_req_o ? req_cnt + 1 : 0;
      if (fll_req_o && fll_ack_i) hold_cnt <= ack_hold;
      else if (!fll_req_o && hold_cnt > 0) hold_cnt <= hold_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One command through the whole handshake, checked against the expected
  // request length, response cycle, data and error flag.
  task automatic run_txn(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdv, input int d, input int h,
                         input int rdy_wait, input string tag);
    logic        acked, err_exp, bad_sig, bad_ready, bad_hold;
    logic [31:0] rdata_exp;
    int          r_exp, rsp_exp, cyc, req_seen, first_req, rsp_cyc;

    acked     = (d + 1 <= int'(T));
    r_exp     = acked ? d + 1 : int'(T);
    err_exp   = !acked || (h >= int'(T));
    rsp_exp   = r_exp + 1 + (acked ? ((h < int'(T)) ? h + 1 : int'(T)) : 1);
    rdata_exp = (!err_exp && !wr) ? rdv : 32'd0;

    chk({tag, ".ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, ".gap"},   32'(fll_req_o),   32'd0);

    ack_delay   = d;
    ack_hold    = h;
    resp_rdata  = rdv;
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    rsp_ready_i = (rdy_wait == 0);

    cyc = 0; req_seen = 0; first_req = -1; rsp_cyc = -1;
    bad_sig = 1'b0; bad_ready = 1'b0; bad_hold = 1'b0;
    while (rsp_cyc < 0 && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
      // valid stays high with junk payload; a busy master must ignore it
      cmd_wr_i    = 1'($urandom);
      cmd_addr_i  = 2'($urandom);
      cmd_wdata_i = $urandom;
      if (fll_req_o) begin
        req_seen++;
        if (first_req < 0) first_req = cyc;
        if (fll_wrn_o !== ~wr || fll_add_o !== addr || fll_data_o !== wdata) bad_sig = 1'b1;
      end
      if (cmd_ready_o !== 1'b0) bad_ready = 1'b1;
      if (rsp_valid_o === 1'b1) rsp_cyc = cyc;
    end
    cmd_valid_i = 1'b0;

    chk({tag, ".req_start"}, 32'(first_req), 32'd1);
    chk({tag, ".req_len"},   32'(req_seen),  32'(r_exp));
    chk({tag, ".req_sig"},   32'(bad_sig),   32'd0);
    chk({tag, ".busy"},      32'(bad_ready), 32'd0);
    chk({tag, ".rsp_cyc"},   32'(rsp_cyc),   32'(rsp_exp));
    chk({tag, ".rdata"},     rsp_rdata_o,    rdata_exp);
    chk({tag, ".err"},       32'(rsp_err_o), 32'(err_exp));

    if (rdy_wait > 0) begin
      for (int i = 0; i < rdy_wait; i++) begin
        @(posedge clk_i); #1;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== rdata_exp ||
            rsp_err_o !== err_exp || cmd_ready_o !== 1'b0) bad_hold = 1'b1;
      end
      chk({tag, ".rsp_hold"}, 32'(bad_hold), 32'd0);
      rsp_ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    chk({tag, ".rsp_drop"},  32'(rsp_valid_o), 32'd0);
    chk({tag, ".ready_back"}, 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    logic        r_wr;
    logic [1:0]  r_addr;
    logic [31:0] r_wdata, r_rdv;
    int          r_d, r_h, r_w, pulses, stuck;

    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = 2'd0; cmd_wdata_i = 32'd0;
    rsp_ready_i = 1'b0; fll_lock_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.ready",     32'(cmd_ready_o), 32'd1);
    chk("rst.req",       32'(fll_req_o),   32'd0);
    chk("rst.wrn",       32'(fll_wrn_o),   32'd0);
    chk("rst.add",       32'(fll_add_o),   32'd0);
    chk("rst.data",      fll_data_o,       32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst.rdata",     rsp_rdata_o,      32'd0);
    chk("rst.err",       32'(rsp_err_o),   32'd0);
    chk("rst.lock",      32'(lock_o),      32'd0);
    chk("rst.lost",      32'(lock_lost_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // directed scenarios
    run_txn(1'b1, 2'd2, 32'hDEADBEEF, 32'h0BAD_CAFE, 0, 0, 0, "wr_comb");
    run_txn(1'b0, 2'd1, 32'h0000_0011, 32'h1234_5678, 5, 0, 0, "rd_delay5");
    run_txn(1'b0, 2'd3, 32'h0000_0022, 32'hFFFF_FFFF, 1000, 0, 0, "ack_never");
    run_txn(1'b1, 2'd0, 32'hA5A5_0001, 32'd0, 0, 0, 3, "b2b_first");
    run_txn(1'b0, 2'd1, 32'hA5A5_0002, 32'hC0DE_0002, 1, 1, 0, "b2b_second");
    run_txn(1'b0, 2'd2, 32'h0, 32'h7777_0007, 7, 0, 0, "ack_last_cycle");
    run_txn(1'b0, 2'd2, 32'h0, 32'h8888_0008, 8, 0, 0, "ack_too_late");
    run_txn(1'b0, 2'd0, 32'h0, 32'h5555_0007, 0, 7, 1, "hold_7");
    run_txn(1'b0, 2'd3, 32'h0, 32'h5555_0008, 2, 8, 0, "hold_timeout");

    // randomized commands
    for (int n = 0; n < 16; n++) begin
      r_wr    = 1'($urandom);
      r_addr  = 2'($urandom);
      r_wdata = $urandom;
      r_rdv   = $urandom;
      case ($urandom_range(0, 7))
        0: r_d = 0;  1: r_d = 1;  2: r_d = 2;  3: r_d = 3;
        4: r_d = 5;  5: r_d = 7;  6: r_d = 8;  default: r_d = 1000;
      endcase
      case ($urandom_range(0, 5))
        0, 1: r_h = 0;  2: r_h = 1;  3: r_h = 2;  4: r_h = 7;  default: r_h = 8;
      endcase
      r_w = int'($urandom_range(0, 3));
      run_txn(r_wr, r_addr, r_wdata, r_rdv, r_d, r_h, r_w, $sformatf("rnd%0d", n));
    end

    // reset in the middle of a request
    ack_delay = 1000; ack_hold = 0;
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 2'd1; cmd_wdata_i = 32'h1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("mid_rst.req_before", 32'(fll_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst.req",       32'(fll_req_o),   32'd0);
    chk("mid_rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst.ready",     32'(cmd_ready_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    stuck = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o !== 1'b0 || fll_req_o !== 1'b0 || cmd_ready_o !== 1'b1) stuck++;
    end
    chk("mid_rst.quiet", 32'(stuck), 32'd0);
    run_txn(1'b1, 2'd3, 32'h600D_F00D, 32'd0, 0, 0, 0, "after_rst");

    // lock synchroniser: rise, then fall
    fll_lock_i = 1'b1;
    pulses = 0;
    @(posedge clk_i); #1;
    chk("lock.rise1", 32'(lock_o), 32'd0);
    pulses += int'(lock_lost_o);
    @(posedge clk_i); #1;
    chk("lock.rise2", 32'(lock_o), 32'd1);
    pulses += int'(lock_lost_o);
    repeat (3) begin
      @(posedge clk_i); #1;
      pulses += int'(lock_lost_o);
    end
    chk("lock.rise_no_pulse", 32'(pulses), 32'd0);
    fll_lock_i = 1'b0;
    @(posedge clk_i); #1;
    chk("lock.fall1", 32'(lock_o), 32'd1);
    chk("lock.fall1_lost", 32'(lock_lost_o), 32'd0);
    @(posedge clk_i); #1;
    chk("lock.fall2", 32'(lock_o), 32'd0);
    pulses = 0;
    pulses += int'(lock_lost_o);
    repeat (4) begin
      @(posedge clk_i); #1;
      pulses += int'(lock_lost_o);
    end
    chk("lock.fall_one_pulse", 32'(pulses), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fll_cfg_master.md
Name: fll_cfg_master

Overview:
Initiator for the FLL configuration interface (fll_req/fll_wrn/fll_add/fll_data/fll_ack/fll_r_data/fll_lock) exposed by the SoC clock/reset generator. It accepts single read/write commands from a local register/bus adapter over a valid/ready port. Each command becomes one four-phase req/ack transaction, and the result returns on a held response port. The block also synchronises fll_lock and flags loss of lock. It sits in the SoC control domain, between the peripheral bus bridge and clk_rst_gen.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait in any handshake phase; 0 disables the timeout.
SYNC_STAGES, 2, flop stages on fll_lock_i; minimum 2.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_wr_i  input  1  1 = write, 0 = read
cmd_addr_i  input  2  FLL register address
cmd_wdata_i  input  32  write data
rsp_valid_o  output  1  response valid, held until rsp_ready_i
rsp_ready_i  input  1  response consumed
rsp_rdata_o  output  32  read data (0 for writes and errors)
rsp_err_o  output  1  1 = handshake timeout
fll_req_o  output  1  transaction request
fll_wrn_o  output  1  0 = write, 1 = read
fll_add_o  output  2  address
fll_data_o  output  32  write data
fll_ack_i  input  1  responder acknowledge; may be combinational from fll_req_o
fll_r_data_i  input  32  read data, valid while fll_ack_i=1
fll_lock_i  input  1  FLL lock, asynchronous
lock_o  output  1  synchronised lock
lock_lost_o  output  1  one-cycle pulse on synchronised lock 1->0

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; all outputs 0 except cmd_ready_o = 1 (comb from IDLE).
  - Timeout counter cleared; sync chain cleared.
- All outputs are registered except cmd_ready_o (= state==IDLE).
- IDLE: on cmd_valid_i=1, capture wr/addr/wdata, go to REQ. Clear the counter.
- REQ:
  - fll_req_o=1, with fll_wrn_o=~wr, fll_add_o, fll_data_o driven from captured values and stable throughout.
  - If fll_ack_i=1: capture fll_r_data_i (reads only; 0 for writes), set err=0, go to RELEASE (req drops next cycle).
  - Else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: set err=1, rdata=0, go to RELEASE.
  - Otherwise increment the counter.
- RELEASE:
  - fll_req_o=0. Counter restarts on entry.
  - When fll_ack_i=0, go to RESP.
  - On timeout with ack still high, set err=1, rdata=0, go to RESP.
- RESP: rsp_valid_o=1 with rsp_rdata_o/rsp_err_o stable. On rsp_ready_i=1, go to IDLE (rsp_valid_o low next cycle).
- fll_req_o is low for at least one full cycle between transactions.
- Latency with a combinational responder (ack=req):
  - cycle 0: command accepted
  - cycle 1: req=1, ack=1
  - cycle 2: req=0, ack=0
  - cycle 3: rsp_valid_o=1
  - With rsp_ready_i held high, the next command is accepted at cycle 4.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- cmd_valid_i in any non-IDLE state is ignored (ready=0); command inputs are not sampled.
- Reset mid-transaction drops fll_req_o and rsp_valid_o immediately, with no response emitted.
- Lock path:
  - fll_lock_i passes through SYNC_STAGES flops to give lock_o.
  - lock_lost_o = previous lock_o & ~current sync value, registered, one cycle wide.
  - lock_o rising produces no pulse.
  - The lock path is independent of the command FSM.

Test Plan:
- Write with responder ack=req comb: cmd wr=1 addr=2 wdata=0xDEADBEEF.
  -> fll_req_o high exactly 1 cycle with wrn=0, add=2, data=0xDEADBEEF.
  -> rsp_valid_o at cycle 3, err=0, rdata=0.
- Read with responder delaying ack 5 cycles, r_data=0x12345678.
  -> req held 6 cycles with stable signals; rsp_rdata_o=0x12345678, err=0.
- Ack never asserted, TIMEOUT_CYCLES=8.
  -> req high 8 cycles, then drops; rsp_err_o=1, rdata=0; next command accepted afterwards.
- Back-to-back commands, rsp_ready_i low 3 cycles.
  -> rsp_valid_o and data held; cmd_ready_o=0 until after the handshake.
  -> second command's req starts only after req was low at least 1 cycle.
- rst_i pulsed while in REQ.
  -> fll_req_o=0 and rsp_valid_o=0 in the same cycle; FSM IDLE; cmd_ready_o=1 after release.
- fll_lock_i 0->1->0.
  -> lock_o follows after SYNC_STAGES cycles; single-cycle lock_lost_o on the fall only.
